instr_encoder_loader: RTL and testbench

Inverse of the pipeline's opcode decoder. Accepts decoded instruction fields (class, funct3/funct7, rd/rs1/rs2, imm) over a valid/ready handshake and assembles the RV32I machine word. Writes each word sequentially into the instruction memory write port starting at BASE_ADDR. Used to load programs into the pipelined core from a bench or host before execution, and to cross-check the decoder.

---
 rtl/instr_encoder_loader_if.sv | 28 ++
 rtl/instr_encoder_loader.sv | 115 +++++++++++
 tb/tb_instr_encoder_loader.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_loader_if.sv
// Field-bundle handshake plus instruction-memory write port for the RV32I encoder/loader.
// master = bundle source / memory sink, slave = the loader block.
interface instr_encoder_loader_if #(
  parameter int ADDR_W = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        cls;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [11:0]       imm;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output in_valid, cls, funct3, funct7, rd, rs1, rs2, imm,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, cls, funct3, funct7, rd, rs1, rs2, imm,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Encodes decoded fields into RV32I words and writes them to imem from BASE_ADDR upward.
// Word appears on the write port one cycle after handshake; in_ready drops during the write cycle (1 word / 2 cycles).
module instr_encoder_loader #(
  parameter int ADDR_W    = 6,
  parameter int BASE_ADDR = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  instr_encoder_loader_if.slave       bus,
  output logic [ADDR_W:0]             count,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);

  typedef enum logic [1:0] {S_IDLE, S_ACCEPT, S_WRITE, S_DONE} state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;

  localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   FULL_M1 = (ADDR_W+1)'((1 << ADDR_W) - 1);

  state_t state;

  // Branch imm carries offset[12:1], so imm[11]=bit12, imm[10]=bit11, imm[9:4]=bits10:5, imm[3:0]=bits4:1.
  function automatic logic [31:0] encode(
    input logic [2:0]  c,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [4:0]  d,
    input logic [4:0]  s1,
    input logic [4:0]  s2,
    input logic [11:0] im
  );
    logic [31:0] w;
    w = '0;
    case (c)
      3'd0:    w = {f7, s2, s1, f3, d, OP_R};
      3'd1:    w = {im, s1, f3, d, OP_LOAD};
      3'd2:    w = {im[11:5], s2, s1, f3, im[4:0], OP_STORE};
      3'd3:    w = {im[11], im[9:4], s2, s1, f3, im[3:0], im[10], OP_BRANCH};
      3'd4:    w = {im, s1, f3, d, OP_IALU};
      default: w = '0;
    endcase
    return w;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      bus.in_ready   <= 1'b0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      count          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state        <= S_ACCEPT;
            count        <= '0;
            err          <= 1'b0;
            done         <= 1'b0;
            busy         <= 1'b1;
            bus.in_ready <= 1'b1;
          end
        end
        S_ACCEPT: begin
          // in_ready is always high here, so in_valid alone marks a transfer.
          if (bus.in_valid) begin
            case (bus.cls)
              3'd5, 3'd6: err <= 1'b1;
              3'd7: begin
                state        <= S_DONE;
                done         <= 1'b1;
                busy         <= 1'b0;
                bus.in_ready <= 1'b0;
              end
              default: begin
                state          <= S_WRITE;
                bus.in_ready   <= 1'b0;
                bus.imem_we    <= 1'b1;
                bus.imem_addr  <= BASE_A + count[ADDR_W-1:0];
                bus.imem_wdata <= encode(bus.cls, bus.funct3, bus.funct7,
                                         bus.rd, bus.rs1, bus.rs2, bus.imm);
              end
            endcase
          end
        end
        S_WRITE: begin
          bus.imem_we <= 1'b0;
          count       <= count + 1'b1;
          if (count == FULL_M1) begin
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state        <= S_ACCEPT;
            bus.in_ready <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: a 64-word instance and a 4-word instance (BASE_ADDR=1) to hit the full/wrap path.
module tb_instr_encoder_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a_start = 1'b0;
  logic b_start = 1'b0;
  logic [6:0] a_count;
  logic [2:0] b_count;
  logic a_busy, a_done, a_err;
  logic b_busy, b_done, b_err;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instr_encoder_loader_if #(.ADDR_W(6)) ba ();
  instr_encoder_loader_if #(.ADDR_W(2)) bb ();

  instr_encoder_loader #(.ADDR_W(6), .BASE_ADDR(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .bus(ba),
    .count(a_count), .busy(a_busy), .done(a_done), .err(a_err)
  );

  instr_encoder_loader #(.ADDR_W(2), .BASE_ADDR(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .bus(bb),
    .count(b_count), .busy(b_busy), .done(b_done), .err(b_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_a(input logic v, input logic [2:0] c, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2, input logic [11:0] im);
    ba.in_valid = v; ba.cls = c; ba.funct3 = f3; ba.funct7 = f7;
    ba.rd = d; ba.rs1 = s1; ba.rs2 = s2; ba.imm = im;
  endtask

  // Sends one legal bundle to dut_a and checks the resulting write and count.
  task automatic write_a(input string tag, input logic [2:0] c, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2, input logic [11:0] im,
                         input logic [31:0] exp_w, input logic [31:0] exp_addr);
    set_a(1'b1, c, f3, f7, d, s1, s2, im);
    tick();
    set_a(1'b0, 3'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 12'd0);
    check({tag, "_we"}, ba.imem_we, 1);
    check({tag, "_addr"}, ba.imem_addr, exp_addr);
    check({tag, "_wdata"}, ba.imem_wdata, exp_w);
    tick();
    check({tag, "_count"}, a_count, exp_addr + 1);
  endtask

  logic [31:0] b_words [4] = '{32'h00000013, 32'h00100093, 32'h00200113, 32'h00300193};
  logic [31:0] b_addrs [4] = '{32'd1, 32'd2, 32'd3, 32'd0};

  initial begin
    set_a(1'b0, 3'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 12'd0);
    bb.in_valid = 1'b0; bb.cls = 3'd0; bb.funct3 = 3'd0; bb.funct7 = 7'd0;
    bb.rd = 5'd0; bb.rs1 = 5'd0; bb.rs2 = 5'd0; bb.imm = 12'd0;
    tick();
    tick();
    check("rst_in_ready", ba.in_ready, 0);
    check("rst_we", ba.imem_we, 0);
    check("rst_addr", ba.imem_addr, 0);
    check("rst_wdata", ba.imem_wdata, 0);
    check("rst_count", a_count, 0);
    check("rst_flags", {a_busy, a_done, a_err}, 0);
    rst_n = 1'b1;
    tick();
    check("idle_in_ready", ba.in_ready, 0);

    // Session 1: add x3,x1,x2 then HALT
    a_start = 1'b1; tick(); a_start = 1'b0;
    check("s1_in_ready", ba.in_ready, 1);
    check("s1_busy", a_busy, 1);
    write_a("add", 3'd0, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 12'd0, 32'h002081B3, 0);
    check("add_ready_back", ba.in_ready, 1);
    set_a(1'b1, 3'd7, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 12'd0);
    tick();
    set_a(1'b0, 3'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 12'd0);
    check("halt_we", ba.imem_we, 0);
    check("halt_flags", {a_busy, a_done, a_err}, 3'b010);
    check("halt_count", a_count, 1);
    check("halt_in_ready", ba.in_ready, 0);
    check("halt_hold_wdata", ba.imem_wdata, 32'h002081B3);
    tick();
    check("done_level", a_done, 1);

    // Session 2: lw then sw with valid held high
    a_start = 1'b1; tick(); a_start = 1'b0;
    check("s2_count", a_count, 0);
    check("s2_done_clr", a_done, 0);
    set_a(1'b1, 3'd1, 3'd2, 7'd0, 5'd5, 5'd1, 5'd0, 12'd8);
    tick();
    check("lw_we", ba.imem_we, 1);
    check("lw_addr", ba.imem_addr, 0);
    check("lw_wdata", ba.imem_wdata, 32'h0080A283);
    check("lw_in_ready", ba.in_ready, 0);
    set_a(1'b1, 3'd2, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 12'd12);
    tick();
    check("lw_gap_we", ba.imem_we, 0);
    check("lw_gap_in_ready", ba.in_ready, 1);
    tick();
    check("sw_we", ba.imem_we, 1);
    check("sw_addr", ba.imem_addr, 1);
    check("sw_wdata", ba.imem_wdata, 32'h0020A623);
    check("sw_in_ready", ba.in_ready, 0);
    set_a(1'b0, 3'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 12'd0);
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    check("start_ignored_count", a_count, 2);
    check("start_ignored_busy", a_busy, 1);

    // Illegal class: flagged, nothing written, stays accepting
    set_a(1'b1, 3'd5, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 12'd0);
    tick();
    set_a(1'b0, 3'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 12'd0);
    check("ill_err", a_err, 1);
    check("ill_we", ba.imem_we, 0);
    check("ill_in_ready", ba.in_ready, 1);
    check("ill_count", a_count, 2);
    write_a("sub", 3'd0, 3'd0, 7'h20, 5'd7, 5'd6, 5'd5, 12'd0, 32'h405303B3, 2);
    write_a("beq", 3'd3, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 12'd4, 32'h00208463, 3);
    write_a("sw_neg", 3'd2, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 12'hFFF, 32'hFE000FA3, 4);
    write_a("bne_neg", 3'd3, 3'd1, 7'd0, 5'd0, 5'd0, 5'd0, 12'hFFF, 32'hFE001FE3, 5);
    write_a("addi", 3'd4, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 12'd5, 32'h00500093, 6);
    set_a(1'b1, 3'd7, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 12'd0);
    tick();
    set_a(1'b0, 3'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 12'd0);
    check("s2_halt_flags", {a_busy, a_done, a_err}, 3'b011);
    check("s2_halt_count", a_count, 7);

    // Session 3: reset during the write cycle
    a_start = 1'b1; tick(); a_start = 1'b0;
    check("s3_err_clr", a_err, 0);
    set_a(1'b1, 3'd0, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 12'd0);
    tick();
    set_a(1'b0, 3'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 12'd0);
    check("pre_rst_we", ba.imem_we, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_we", ba.imem_we, 0);
    check("mid_rst_count", a_count, 0);
    check("mid_rst_wdata", ba.imem_wdata, 0);
    check("mid_rst_flags", {a_busy, a_done, a_err, ba.in_ready}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_idle", {a_busy, ba.in_ready}, 0);
    a_start = 1'b1; tick(); a_start = 1'b0;
    check("post_rst_start", {a_busy, ba.in_ready}, 2'b11);

    // Small instance: fill all 4 words with valid held, address wraps from BASE_ADDR=1
    b_start = 1'b1; tick(); b_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bb.in_valid = 1'b1; bb.cls = 3'd4; bb.funct3 = 3'd0;
      bb.rd = 5'(i); bb.rs1 = 5'd0; bb.imm = 12'(i);
      check("b_in_ready", bb.in_ready, 1);
      tick();
      check("b_we", bb.imem_we, 1);
      check("b_addr", bb.imem_addr, b_addrs[i]);
      check("b_wdata", bb.imem_wdata, b_words[i]);
      tick();
    end
    check("b_full_done", b_done, 1);
    check("b_full_count", b_count, 4);
    check("b_full_ready", {bb.in_ready, b_busy}, 0);
    tick();
    check("b_full_hold_we", bb.imem_we, 0);
    check("b_full_hold_count", b_count, 4);
    bb.in_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
